lcd_rx_4: RTL

Cycle-accurate HD44780-style LCD responder for the 4-bit Pmod SC1602 bus. It sits on the panel side of the bus, in simulation benches and in loopback FPGA builds, and decodes the enable/RS/RW/nibble strobes issued by the LCD write driver. It executes the instruction subset into an 80-byte DDRAM and exposes display state plus a host readback port so frame contents can be checked without a physical panel.

---
 rtl/lcd_rx_4_if.sv | 25 ++
 rtl/lcd_rx_4.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rx_4_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_rx_4_if
// Brief    : 4-bit HD44780 bus between LCD write driver (master) and panel.
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_rx_4_if;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [3:0] lcd_data;
    logic [3:0] lcd_data_out;
    logic       lcd_data_oe;

    modport master (
        output lcd_en, lcd_rs, lcd_rw, lcd_data,
        input  lcd_data_out, lcd_data_oe
    );

    modport slave (
        input  lcd_en, lcd_rs, lcd_rw, lcd_data,
        output lcd_data_out, lcd_data_oe
    );
endinterface
`default_nettype wire

// File: rtl/lcd_rx_4.sv
`default_nettype none
// ============================================================================
// Module   : lcd_rx_4
// Brief    : HD44780-style panel responder with 80-byte DDRAM and host
//            readback. Define LCD_RX_READ_EN to enable the bus read path.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_rx_4 #(
    parameter int BUSY_CYCLES = 2,
    parameter int HOME_CYCLES = 40
) (
    input  logic        clk,
    input  logic        reset,
    lcd_rx_4_if.slave   bus,
    output logic        busy,
    output logic [6:0]  ac,
    output logic        four_bit,
    output logic        two_line,
    output logic        disp_on,
    output logic        cursor_on,
    output logic        blink_on,
    output logic        incr,
    output logic        err,
    input  logic [6:0]  rd_addr,
    output logic [7:0]  rd_data
);
    localparam int c_CELLS   = 80;
    localparam int c_CNT_MAX = (HOME_CYCLES > BUSY_CYCLES) ? HOME_CYCLES : BUSY_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [6:0] c_LAST_CELL = 7'(c_CELLS - 1);

    // Returns {mapped, cell index}
    function automatic logic [7:0] f_map(input logic [6:0] a, input logic two);
        if (two) begin
            if (a <= 7'h27)                    f_map = {1'b1, a};
            else if (a >= 7'h40 && a <= 7'h67) f_map = {1'b1, a - 7'd24};
            else                               f_map = 8'h00;
        end else if (a <= 7'h4F)               f_map = {1'b1, a};
        else                                   f_map = 8'h00;
    endfunction

    function automatic logic [6:0] f_step(input logic [6:0] a, input logic up, input logic two);
        if (up) begin
            if (two && a == 7'h27)       f_step = 7'h40;
            else if (two && a == 7'h67)  f_step = 7'h00;
            else if (!two && a == 7'h4F) f_step = 7'h00;
            else                         f_step = a + 7'd1;
        end else begin
            if (two && a == 7'h00)       f_step = 7'h67;
            else if (two && a == 7'h40)  f_step = 7'h27;
            else if (!two && a == 7'h00) f_step = 7'h4F;
            else                         f_step = a - 7'd1;
        end
    endfunction

    logic [7:0]         r_ddram [0:c_CELLS-1];
    logic               r_en_q;
    logic               r_phase;
    logic [3:0]         r_hi;
    logic               r_fill_active;
    logic [6:0]         r_fill_idx;
    logic [c_CNT_W-1:0] r_cnt;

    logic       w_fall;
    logic       w_wr_fall;
    logic       w_rd_fall;
    logic [7:0] w_byte;
    logic [7:0] w_ac_map;
    logic [7:0] w_rd_map;
    logic       w_mem_we;
    logic [6:0] w_mem_addr;
    logic [7:0] w_mem_wdata;

    assign w_fall    = r_en_q & ~bus.lcd_en;
    assign w_wr_fall = w_fall & ~bus.lcd_rw;
    assign w_rd_fall = w_fall & bus.lcd_rw;
    assign w_byte    = four_bit ? {r_hi, bus.lcd_data} : {bus.lcd_data, 4'h0};
    assign w_ac_map  = f_map(ac, two_line);
    assign w_rd_map  = f_map(rd_addr, two_line);

    // Fill owns the write port; bus writes cannot overlap since busy covers the fill
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_fill_idx;
        w_mem_wdata = 8'h20;
        if (r_fill_active) begin
            w_mem_we = 1'b1;
        end else if (w_wr_fall && !busy && bus.lcd_rs && (!four_bit || r_phase) && w_ac_map[7]) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = w_ac_map[6:0];
            w_mem_wdata = w_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) r_ddram[w_mem_addr] <= w_mem_wdata;
    end

`ifdef LCD_RX_READ_EN
    logic       w_rise;
    logic [7:0] w_rd_byte;
    logic [3:0] r_data_out;
    logic       r_data_oe;

    assign w_rise    = ~r_en_q & bus.lcd_en;
    assign w_rd_byte = bus.lcd_rs ? (w_ac_map[7] ? r_ddram[w_ac_map[6:0]] : 8'h00) : {busy, ac};
    assign bus.lcd_data_out = r_data_out;
    assign bus.lcd_data_oe  = r_data_oe;
`else
    assign bus.lcd_data_out = 4'h0;
    assign bus.lcd_data_oe  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en_q        <= 1'b0;
            r_phase       <= 1'b0;
            r_hi          <= 4'h0;
            r_fill_active <= 1'b1;
            r_fill_idx    <= 7'd0;
            r_cnt         <= '0;
            busy          <= 1'b1;
            ac            <= 7'd0;
            four_bit      <= 1'b0;
            two_line      <= 1'b0;
            disp_on       <= 1'b0;
            cursor_on     <= 1'b0;
            blink_on      <= 1'b0;
            incr          <= 1'b0;
            err           <= 1'b0;
            rd_data       <= 8'h00;
`ifdef LCD_RX_READ_EN
            r_data_out    <= 4'h0;
            r_data_oe     <= 1'b0;
`endif
        end else begin
            r_en_q  <= bus.lcd_en;
            rd_data <= w_rd_map[7] ? r_ddram[w_rd_map[6:0]] : 8'h00;

            if (r_fill_active) begin
                if (r_fill_idx == c_LAST_CELL) r_fill_active <= 1'b0;
                else                           r_fill_idx    <= r_fill_idx + 7'd1;
            end

            // Busy drops once both the countdown and any clear-fill are done
            if (busy) begin
                if (r_cnt != '0)
                    r_cnt <= r_cnt - 1'b1;
                else if (!r_fill_active || r_fill_idx == c_LAST_CELL)
                    busy <= 1'b0;
            end

            if (w_wr_fall) begin
                if (busy) begin
                    err <= 1'b1;
                    if (four_bit) r_phase <= ~r_phase;
                end else if (four_bit && !r_phase) begin
                    r_hi    <= bus.lcd_data;
                    r_phase <= 1'b1;
                end else begin
                    r_phase <= 1'b0;
                    busy    <= 1'b1;
                    r_cnt   <= c_CNT_W'(BUSY_CYCLES - 1);
                    if (bus.lcd_rs) begin
                        if (!w_ac_map[7]) err <= 1'b1;
                        ac <= f_step(ac, incr, two_line);
                    end else begin
                        casez (w_byte)
                            8'b1???????: ac <= w_byte[6:0];
                            8'b01??????: ;
                            8'b001?????: begin
                                four_bit <= ~w_byte[4];
                                two_line <= w_byte[3];
                            end
                            8'b0001????: if (!w_byte[3]) ac <= f_step(ac, w_byte[2], two_line);
                            8'b00001???: begin
                                disp_on   <= w_byte[2];
                                cursor_on <= w_byte[1];
                                blink_on  <= w_byte[0];
                            end
                            8'b000001??: incr <= w_byte[1];
                            8'b0000001?: begin
                                ac    <= 7'd0;
                                r_cnt <= c_CNT_W'(HOME_CYCLES - 1);
                            end
                            8'b00000001: begin
                                ac            <= 7'd0;
                                incr          <= 1'b1;
                                r_cnt         <= c_CNT_W'(HOME_CYCLES - 1);
                                r_fill_active <= 1'b1;
                                r_fill_idx    <= 7'd0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

`ifdef LCD_RX_READ_EN
            // Reads are honoured even while busy; data reads advance ac on the completing fall
            if (w_rd_fall) begin
                if (four_bit) r_phase <= ~r_phase;
                if (bus.lcd_rs && (!four_bit || r_phase)) ac <= f_step(ac, incr, two_line);
            end
            if (w_rise && bus.lcd_rw)
                r_data_out <= r_phase ? w_rd_byte[3:0] : w_rd_byte[7:4];
            r_data_oe <= bus.lcd_rw & bus.lcd_en;
`else
            if (w_rd_fall) err <= 1'b1;
`endif
        end
    end
endmodule
`default_nettype wire
